muldiv_control: RTL and testbench
=================================

Name: muldiv_control

Overview:
Iterative multiply/divide sequencer for the execute stage. It owns the HI/LO register pair and runs MULT/MULTU/DIV/DIVU as a radix-2 shift-add or restoring-divide loop, one bit per cycle. It also services MFHI/MFLO/MTHI/MTLO. It raises a stall to the pipeline only when an instruction touches HI/LO or the unit while an operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
EX_start  input  1  valid HI/LO-class instruction in EX this cycle
EX_op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MFHI, 101 MFLO, 110 MTHI, 111 MTLO
EX_rs_data  input  WIDTH  multiplicand/dividend; MTHI/MTLO source
EX_rt_data  input  WIDTH  multiplier/divisor
EX_flush  input  1  abort in-flight operation
EX_stall  output  1  hold the EX stage this cycle (combinational)
EX_busy  output  1  operation in flight (state != IDLE)
EX_hilo_out  output  WIDTH  MFHI/MFLO result (combinational: EX_op[0] ? LO : HI)

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, HI=LO=0, counter=0, internal accumulators=0. EX_busy=0, EX_stall=0, EX_hilo_out=0. Reset mid-operation discards the operation silently.
- States: IDLE, CALC, SIGN.
- EX_stall = EX_start && (state != IDLE). When stalled, the instruction is not accepted and is re-presented next cycle.
- IDLE, EX_start, op MFHI/MFLO: EX_hilo_out is valid in the same cycle. No state change.
- IDLE, EX_start, op MTHI/MTLO: the selected register gets EX_rs_data at the next edge.
- IDLE, EX_start, mul/div op: latch operands at edge N, counter=0, go to CALC.
  - Signed ops latch absolute values plus the sign flags of rs and rt.
  - Unsigned ops latch the raw operands with sign flags 0.
- CALC: one iteration per edge, N+1..N+WIDTH. The counter increments each edge. When counter==WIDTH-1, go to SIGN.
  - Multiply: 2*WIDTH product register. Add the multiplicand if the product LSB is 1, then shift right 1. The carry-out enters the MSB.
  - Divide: restoring. Shift {rem,quot} left 1, trial-subtract the divisor from rem. If the result is non-negative, keep it and set the quot LSB.
- SIGN, edge N+WIDTH+1: write HI/LO and return to IDLE.
  - MULT: product negated (two's complement, 2*WIDTH) if the sign flags differ. HI=upper, LO=lower.
  - DIV: quotient negated if the sign flags differ; remainder negated if the rs sign is 1. LO=quotient, HI=remainder.
  - Unsigned ops: no negation.
- Total latency: start at edge N → HI/LO updated at edge N+WIDTH+1 (33 for WIDTH=32). EX_busy is high from after edge N through edge N+WIDTH+1.
- Divide by zero (rt==0, DIV or DIVU): skip CALC and go IDLE→SIGN at edge N. At edge N+1: LO=all ones, HI=EX_rs_data as latched (raw, not abs). Not a trap.
- DIV of most-negative by -1: quotient is the most-negative value, remainder 0. This falls out of the modulo-2^WIDTH abs/negate; no special case.
- EX_flush: at the next edge, return to IDLE from any state. HI/LO are unchanged and the counter clears. Flush has priority over completion: flush in SIGN means no write.
  - Flush in the same cycle as EX_start in IDLE: the start is dropped.
- Reset has priority over flush and start.
- MFHI/MFLO issued the cycle after SIGN sees the new values.
- A back-to-back mul/div start in the cycle state returns to IDLE is accepted.
- Arithmetic is modulo 2^WIDTH or 2^(2*WIDTH); no overflow flags.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → EX_busy for 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001; MFLO next cycle gives 0x00000001 with EX_stall=0.
- MULT 0xFFFFFFFD (-3) × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 0x1234 / 0 → after 2 edges LO=0xFFFFFFFF, HI=0x00001234.
- MULT start, then MFHI presented 1 cycle later → EX_stall=1 for 32 consecutive cycles, deasserts the cycle after HI/LO update, and EX_hilo_out equals the new HI.
- MTLO 0xA5A5A5A5 at IDLE, then MULT, then EX_flush at cycle 10 → EX_busy drops after the flush edge and LO stays 0xA5A5A5A5. Reset asserted mid-CALC → all outputs 0 at the next edge, HI=LO=0.

Source files
------------

// File: rtl/muldiv_control.sv
// Iterative multiply/divide sequencer with HI/LO register pair.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle;
// sign handling is done once on entry (abs) and once on exit (negate).
module muldiv_control #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EX_start,
    input  logic [2:0]       EX_op,
    input  logic [WIDTH-1:0] EX_rs_data,
    input  logic [WIDTH-1:0] EX_rt_data,
    input  logic             EX_flush,
    output logic             EX_stall,
    output logic             EX_busy,
    output logic [WIDTH-1:0] EX_hilo_out
);

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t               state, state_nx;
    logic [WIDTH-1:0]     hi, lo;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;      // product, or {rem, quot}
    logic [WIDTH-1:0]     opnd;     // multiplicand or divisor (absolute)
    logic                 is_div;
    logic                 sign_s, sign_t;
    logic                 dz;

    // Operand preparation for a new mul/div
    logic                 op_signed, rs_neg, rt_neg, start_dz;
    logic [WIDTH-1:0]     rs_abs, rt_abs, acc_hi_init;

    // Iteration datapath
    logic [WIDTH-1:0]     mul_add;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_nx;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   div_nx;

    // Final sign correction
    logic                 res_neg;
    logic [2*WIDTH-1:0]   prod_fin;
    logic [WIDTH-1:0]     quot_fin, rem_fin;

    assign op_signed   = ~EX_op[0];
    assign rs_neg      = op_signed & EX_rs_data[WIDTH-1];
    assign rt_neg      = op_signed & EX_rt_data[WIDTH-1];
    assign rs_abs      = rs_neg ? ('0 - EX_rs_data) : EX_rs_data;
    assign rt_abs      = rt_neg ? ('0 - EX_rt_data) : EX_rt_data;
    assign start_dz    = EX_op[1] && (EX_rt_data == '0);
    // Divide-by-zero parks the raw dividend in the upper half so SIGN can write it to HI
    assign acc_hi_init = start_dz ? EX_rs_data : '0;

    // Multiply: add multiplicand on product LSB, carry-out shifts into the MSB
    assign mul_add   = acc[0] ? opnd : '0;
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    assign mul_nx    = {mul_sum, acc[WIDTH-1:1]};

    // Divide: trial-subtract on the shifted remainder (WIDTH+1 bits to hold the shift-out)
    assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    assign div_nx    = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign res_neg   = sign_s ^ sign_t;
    assign prod_fin  = res_neg ? ('0 - acc) : acc;
    assign quot_fin  = res_neg ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    assign rem_fin   = sign_s ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];

    assign EX_busy     = (state != IDLE);
    assign EX_stall    = EX_start && (state != IDLE);
    assign EX_hilo_out = EX_op[0] ? lo : hi;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (EX_start && !EX_op[2]) state_nx = start_dz ? SIGN : CALC;
            CALC:    if (cnt == LAST) state_nx = SIGN;
            SIGN:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (EX_flush) state_nx = IDLE;
    end

    // HI/LO, operand latches, iteration counter and accumulator
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            sign_s <= 1'b0;
            sign_t <= 1'b0;
            dz     <= 1'b0;
        end else if (EX_flush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (EX_start) begin
                        case (EX_op)
                            3'b110: hi <= EX_rs_data;
                            3'b111: lo <= EX_rs_data;
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                is_div <= EX_op[1];
                                sign_s <= rs_neg;
                                sign_t <= rt_neg;
                                dz     <= start_dz;
                                acc    <= {acc_hi_init, rs_abs};
                                opnd   <= rt_abs;
                                cnt    <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    acc <= is_div ? div_nx : mul_nx;
                end
                SIGN: begin
                    cnt <= '0;
                    if (dz) begin
                        hi <= acc[2*WIDTH-1:WIDTH];
                        lo <= '1;
                    end else if (is_div) begin
                        hi <= rem_fin;
                        lo <= quot_fin;
                    end else begin
                        hi <= prod_fin[2*WIDTH-1:WIDTH];
                        lo <= prod_fin[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_control.sv
// Self-checking bench for muldiv_control: expected HI/LO pairs are queued
// when an operation is issued and compared when read back via MFHI/MFLO.
module tb_muldiv_control;

    localparam int W = 32;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MFHI  = 3'b100;
    localparam logic [2:0] OP_MFLO  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         EX_start;
    logic [2:0]   EX_op;
    logic [W-1:0] EX_rs_data;
    logic [W-1:0] EX_rt_data;
    logic         EX_flush;
    logic         EX_stall;
    logic         EX_busy;
    logic [W-1:0] EX_hilo_out;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb_q[$];

    muldiv_control #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .EX_start    (EX_start),
        .EX_op       (EX_op),
        .EX_rs_data  (EX_rs_data),
        .EX_rt_data  (EX_rt_data),
        .EX_flush    (EX_flush),
        .EX_stall    (EX_stall),
        .EX_busy     (EX_busy),
        .EX_hilo_out (EX_hilo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result {HI, LO}
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] ua, ub, uq, ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OP_MULT:  return sa * sb;
            OP_MULTU: return ua * ub;
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == OP_DIV) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    return {sr[31:0], sq[31:0]};
                end
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    task automatic wait_idle(input string tag, input int exp_cycles);
        int n = 0;
        while (EX_busy && n < 200) begin
            n++;
            tick();
        end
        check(tag, n, exp_cycles);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_busy);
        sb_q.push_back(model(op, a, b));
        EX_start = 1'b1; EX_op = op; EX_rs_data = a; EX_rt_data = b;
        #1;
        check({tag, "_start_stall"}, EX_stall, 0);
        tick();
        EX_start = 1'b0;
        wait_idle({tag, "_busy"}, exp_busy);
    endtask

    // Reads HI then LO in the current (idle) cycle; does not advance the clock
    task automatic check_result(input string tag);
        logic [63:0] exp;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 0, 1);
            return;
        end
        exp = sb_q.pop_front();
        EX_start = 1'b1; EX_op = OP_MFHI;
        #1;
        check({tag, "_rd_stall"}, EX_stall, 0);
        check({tag, "_hi"}, EX_hilo_out, exp[63:32]);
        EX_op = OP_MFLO;
        #1;
        check({tag, "_lo"}, EX_hilo_out, exp[31:0]);
        EX_start = 1'b0;
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        EX_start = 1'b1; EX_op = OP_MFHI;
        #1;
        check({tag, "_hi"}, EX_hilo_out, exp_hi);
        EX_op = OP_MFLO;
        #1;
        check({tag, "_lo"}, EX_hilo_out, exp_lo);
        EX_start = 1'b0;
    endtask

    initial begin
        int n;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] exp;

        rst_n = 1'b0; EX_start = 1'b0; EX_op = OP_MULT; EX_flush = 1'b0;
        EX_rs_data = '0; EX_rt_data = '0;
        repeat (3) tick();
        EX_start = 1'b1;
        #1;
        check("rst_busy", EX_busy, 0);
        check("rst_stall", EX_stall, 0);
        read_hilo("rst", 32'h0, 32'h0);
        rst_n = 1'b1;
        tick();

        // Directed arithmetic cases
        run_op("multu_ff", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        check_result("multu_ff");
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 33);
        check_result("mult_neg");
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33);
        check_result("div_m7_2");
        run_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, 33);
        check_result("divu_7_2");
        run_op("div_minneg", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33);
        check_result("div_minneg");
        run_op("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0, 1);
        check_result("divu_zero");
        run_op("div_zero_neg", OP_DIV, 32'hFFFF_FF00, 32'd0, 1);
        check_result("div_zero_neg");
        run_op("div_pos_neg", OP_DIV, 32'd100, 32'hFFFF_FFF9, 33);
        check_result("div_pos_neg");

        // Random mix, issued back-to-back in the first idle cycle
        for (int i = 0; i < 10; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i == 5) rb = 32'd0;
            run_op("rand", rop, ra, rb, (rop[1] && rb == 32'd0) ? 1 : 33);
            check_result("rand");
        end

        // MFHI presented while MULT in flight stalls until HI/LO written
        sb_q.push_back(model(OP_MULT, 32'hFFFF_FF85, 32'd1000));
        EX_start = 1'b1; EX_op = OP_MULT; EX_rs_data = 32'hFFFF_FF85; EX_rt_data = 32'd1000;
        tick();
        EX_start = 1'b0;
        check("stall_busy", EX_busy, 1);
        tick();
        EX_start = 1'b1; EX_op = OP_MFHI;
        #1;
        n = 0;
        while (EX_stall && n < 200) begin
            n++;
            tick();
        end
        check("stall_cycles", n, 32);
        exp = sb_q.pop_front();
        check("stall_hi", EX_hilo_out, exp[63:32]);
        EX_op = OP_MFLO;
        #1;
        check("stall_lo", EX_hilo_out, exp[31:0]);
        EX_start = 1'b0;
        tick();

        // MTLO/MTHI then a flushed MULT leaves HI/LO intact
        EX_start = 1'b1; EX_op = OP_MTLO; EX_rs_data = 32'hA5A5_A5A5;
        tick();
        EX_op = OP_MTHI; EX_rs_data = 32'h1357_9BDF;
        tick();
        EX_start = 1'b0;
        read_hilo("mt", 32'h1357_9BDF, 32'hA5A5_A5A5);
        EX_start = 1'b1; EX_op = OP_MULT; EX_rs_data = 32'd7; EX_rt_data = 32'd9;
        tick();
        EX_start = 1'b0;
        repeat (9) tick();
        check("flush_pre_busy", EX_busy, 1);
        EX_flush = 1'b1;
        tick();
        EX_flush = 1'b0;
        check("flush_busy", EX_busy, 0);
        read_hilo("flush", 32'h1357_9BDF, 32'hA5A5_A5A5);

        // Flush landing in SIGN suppresses the write
        EX_start = 1'b1; EX_op = OP_MULTU; EX_rs_data = 32'd3; EX_rt_data = 32'd4;
        tick();
        EX_start = 1'b0;
        repeat (32) tick();
        check("sign_busy", EX_busy, 1);
        EX_flush = 1'b1;
        tick();
        EX_flush = 1'b0;
        check("sign_flush_busy", EX_busy, 0);
        read_hilo("sign_flush", 32'h1357_9BDF, 32'hA5A5_A5A5);

        // Start coincident with flush in IDLE is dropped
        EX_start = 1'b1; EX_op = OP_MULT; EX_flush = 1'b1;
        tick();
        check("flush_start_busy", EX_busy, 0);
        EX_op = OP_MTLO; EX_rs_data = 32'hDEAD_BEEF;
        tick();
        EX_flush = 1'b0; EX_start = 1'b0;
        read_hilo("flush_mt", 32'h1357_9BDF, 32'hA5A5_A5A5);

        // Reset mid-CALC discards operation and clears HI/LO
        EX_start = 1'b1; EX_op = OP_MULT; EX_rs_data = 32'd11; EX_rt_data = 32'd13;
        tick();
        EX_start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        EX_start = 1'b1; EX_op = OP_MFHI;
        #1;
        check("rst_mid_busy", EX_busy, 0);
        check("rst_mid_stall", EX_stall, 0);
        read_hilo("rst_mid", 32'h0, 32'h0);
        rst_n = 1'b1;
        tick();

        // Operation still completes normally after reset
        run_op("post_rst", OP_DIVU, 32'd1000, 32'd7, 33);
        check_result("post_rst");

        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
